// File: rtl/multicycle_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : multicycle_controller
// Description : Control FSM for a shared-memory multicycle RV32I datapath.
//               Optional retired-instruction counter: define MCTRL_INSTRET_EN.
// Revision    : 1.0
// ============================================================================
module multicycle_controller
`ifdef MCTRL_INSTRET_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7_bit5,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [1:0]       ImmSrc,
    output logic             RegWrite,
`ifdef MCTRL_INSTRET_EN
    output logic [CNT_W-1:0] instret,
`endif
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    typedef struct packed {
        logic       adr;
        logic       mw;
        logic       rw;
        logic       jal_pc;
        logic       fetch;
        logic       beq;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] aluop;
    } ctrl_t;

    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_BEQ  = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;

    state_t r_state;
    state_t w_next;
    ctrl_t  r_ctrl;

    // Moore controls for a given state; registered alongside the state itself.
    function automatic ctrl_t ctrl_for(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.fetch = 1'b1; c.sb = 2'b10; c.rs = 2'b10; end
            S_DECODE:   begin c.sa = 2'b01; c.sb = 2'b01; end
            S_MEMADR:   begin c.sa = 2'b10; c.sb = 2'b01; end
            S_MEMREAD:  begin c.adr = 1'b1; end
            S_MEMWB:    begin c.rs = 2'b01; c.rw = 1'b1; end
            S_MEMWRITE: begin c.adr = 1'b1; c.mw = 1'b1; end
            S_EXECUTER: begin c.sa = 2'b10; c.aluop = 2'b10; end
            S_EXECUTEI: begin c.sa = 2'b10; c.sb = 2'b01; c.aluop = 2'b10; end
            S_ALUWB:    begin c.rw = 1'b1; end
            S_BEQ:      begin c.beq = 1'b1; c.sa = 2'b10; c.aluop = 2'b01; end
            S_JAL:      begin c.jal_pc = 1'b1; c.sa = 2'b01; c.sb = 2'b10; end
            default:    begin c.fetch = 1'b1; c.sb = 2'b10; c.rs = 2'b10; end
        endcase
        return c;
    endfunction

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_R:           w_next = S_EXECUTER;
                    c_OP_I:           w_next = S_EXECUTEI;
                    c_OP_BEQ:         w_next = S_BEQ;
                    c_OP_JAL:         w_next = S_JAL;
                    default:          w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_ctrl  <= ctrl_for(S_FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_for(w_next);
        end
    end

    // Mealy strobes are gated by rst_n so they stay low for the whole reset.
    assign IRWrite   = rst_n & r_ctrl.fetch & mem_ready;
    assign PCWrite   = rst_n & ((r_ctrl.fetch & mem_ready) | r_ctrl.jal_pc | (r_ctrl.beq & Zero));
    assign MemWrite  = r_ctrl.mw;
    assign RegWrite  = r_ctrl.rw;
    assign AdrSrc    = r_ctrl.adr;
    assign ResultSrc = r_ctrl.rs;
    assign ALUSrcA   = r_ctrl.sa;
    assign ALUSrcB   = r_ctrl.sb;
    assign state_o   = r_state;

    always_comb begin
        ALUControl = 3'b000;
        case (r_ctrl.aluop)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7_bit5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            c_OP_SW:  ImmSrc = 2'b01;
            c_OP_BEQ: ImmSrc = 2'b10;
            c_OP_JAL: ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

`ifdef MCTRL_INSTRET_EN
    logic w_retire;

    // Only completed instructions count; an illegal opcode leaves via DECODE.
    assign w_retire = (w_next == S_FETCH) &&
                      ((r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                       (r_state == S_ALUWB) || (r_state == S_BEQ));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (w_retire) begin
            instret <= instret + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire
